// File: rtl/router10_pkg.sv
// Shared types and constants for the router10 grant scheduler.
package router10_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } sched_state_e;

    localparam int OUT_P  = 0;
    localparam int OUT_C1 = 1;
    localparam int OUT_C2 = 2;

    localparam logic [1:0] GRANT_NONE = 2'b00;

    // Maps a requester index onto the one-hot merge select.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/router10_grant_sched_grant_rr2.sv
// Single-output two-requester round-robin grant scheduler.
// Optional watchdog guarded by ROUTER10_GRANT_WATCHDOG_EN.
module grant_rr2
    import router10_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       tail,
    output logic [1:0] grant,
    output logic       busy,
    output logic       timeout_err
);

    sched_state_e state_q, state_d;
    logic         ptr_q, ptr_d;
    logic         owner_q, owner_d;
    logic         win_idx;

`ifdef ROUTER10_GRANT_WATCHDOG_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
`else
    localparam int unused_cfg = TIMEOUT_CYCLES + CNT_W;
`endif

    // Next-state, pointer and watchdog logic. GAP lasts exactly one cycle and
    // its exit edge arbitrates like IDLE, so a held request regains the merge
    // two edges after the tail.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
`ifdef ROUTER10_GRANT_WATCHDOG_EN
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
`endif
        win_idx = (req == 2'b11) ? ptr_q : req[1];

        case (state_q)
            IDLE, GAP: begin
                if (|req) begin
                    state_d = BUSY;
                    owner_d = win_idx;
                    ptr_d   = ~win_idx;
`ifdef ROUTER10_GRANT_WATCHDOG_EN
                    cnt_d   = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
`ifdef ROUTER10_GRANT_WATCHDOG_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                if (tail) begin
                    state_d = GAP;
                end
`ifdef ROUTER10_GRANT_WATCHDOG_EN
                else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d = GAP;
                    tmo_d   = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

`ifdef ROUTER10_GRANT_WATCHDOG_EN
    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign grant = (state_q == BUSY) ? onehot2(owner_q) : GRANT_NONE;
    assign busy  = (state_q == BUSY);

endmodule

// File: rtl/router10_grant_sched.sv
// Grant scheduler for the three merge points (P, C1, C2) of a tree router node.
// Optional per-output watchdog guarded by ROUTER10_GRANT_WATCHDOG_EN.
module router10_grant_sched
    import router10_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] p_req,
    input  logic [1:0] c1_req,
    input  logic [1:0] c2_req,
    input  logic       p_tail,
    input  logic       c1_tail,
    input  logic       c2_tail,
    output logic [1:0] p_grant,
    output logic [1:0] c1_grant,
    output logic [1:0] c2_grant,
    output logic [2:0] busy,
    output logic [2:0] timeout_err
);

    grant_rr2 #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_sched_p (
        .clk         (CLK),
        .reset       (RESET),
        .req         (p_req),
        .tail        (p_tail),
        .grant       (p_grant),
        .busy        (busy[OUT_P]),
        .timeout_err (timeout_err[OUT_P])
    );

    grant_rr2 #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_sched_c1 (
        .clk         (CLK),
        .reset       (RESET),
        .req         (c1_req),
        .tail        (c1_tail),
        .grant       (c1_grant),
        .busy        (busy[OUT_C1]),
        .timeout_err (timeout_err[OUT_C1])
    );

    grant_rr2 #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_sched_c2 (
        .clk         (CLK),
        .reset       (RESET),
        .req         (c2_req),
        .tail        (c2_tail),
        .grant       (c2_grant),
        .busy        (busy[OUT_C2]),
        .timeout_err (timeout_err[OUT_C2])
    );

endmodule

// File: tb/tb_router10_grant_sched.sv
// Testbench for router10_grant_sched: vector table plus watchdog/hold sequence.
module tb_router10_grant_sched;

    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] p_req, c1_req, c2_req;
    logic       p_tail, c1_tail, c2_tail;
    logic [1:0] p_grant, c1_grant, c2_grant;
    logic [2:0] busy, timeout_err;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic        rst;
        logic [1:0]  p_req;
        logic [1:0]  c1_req;
        logic [1:0]  c2_req;
        logic [2:0]  tail;
        logic [11:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs[$];
    logic [11:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    router10_grant_sched #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK         (clk),
        .RESET       (reset),
        .p_req       (p_req),
        .c1_req      (c1_req),
        .c2_req      (c2_req),
        .p_tail      (p_tail),
        .c1_tail     (c1_tail),
        .c2_tail     (c2_tail),
        .p_grant     (p_grant),
        .c1_grant    (c1_grant),
        .c2_grant    (c2_grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // Builds one vector; tail is {c2,c1,p}, expected is {p,c1,c2,busy,terr}.
    function automatic vec_t mk(input logic rst, input logic [1:0] pr, input logic [1:0] c1r,
                                input logic [1:0] c2r, input logic [2:0] tl, input logic [1:0] ep,
                                input logic [1:0] ec1, input logic [1:0] ec2, input logic [2:0] eb,
                                input logic [2:0] et, input string nm);
        vec_t v;
        v.rst = rst; v.p_req = pr; v.c1_req = c1r; v.c2_req = c2r; v.tail = tl;
        v.exp = {ep, ec1, ec2, eb, et};
        v.name = nm;
        return v;
    endfunction

    // Pops the oldest expectation and compares it with the registered outputs.
    task automatic checkOutput();
        logic [11:0] act;
        logic [11:0] e;
        string       nm;
        act = {p_grant, c1_grant, c2_grant, busy, timeout_err};
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_empty: got %b required an expectation", act);
        end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (act !== e) begin
                tests_failed++;
                $display("[TB] FAIL %s: got p=%b c1=%b c2=%b busy=%b terr=%b, required p=%b c1=%b c2=%b busy=%b terr=%b",
                         nm, act[11:10], act[9:8], act[7:6], act[5:3], act[2:0],
                         e[11:10], e[9:8], e[7:6], e[5:3], e[2:0]);
            end
        end
    endtask

    // Drives one vector before an edge, queues its expectation, checks after the edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset   = v.rst;
        p_req   = v.p_req;
        c1_req  = v.c1_req;
        c2_req  = v.c2_req;
        p_tail  = v.tail[0];
        c1_tail = v.tail[1];
        c2_tail = v.tail[2];
        exp_q.push_back(v.exp);
        name_q.push_back(v.name);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        vec_t        v;
        logic [1:0]  eg;
        logic [2:0]  eb, et;

        reset = 1'b1;
        p_req = '0; c1_req = '0; c2_req = '0;
        p_tail = 1'b0; c1_tail = 1'b0; c2_tail = 1'b0;

        // Reset and single P requester, tail, re-grant, ignored tail
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, "reset_state"));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, "idle_after_reset"));
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b01, 2'b00, 2'b00, 3'b001, 3'b000, "p_first_grant"));
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b01, 2'b00, 2'b00, 3'b001, 3'b000, "p_grant_hold"));
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, 3'b001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, "p_tail_gap"));
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b01, 2'b00, 2'b00, 3'b001, 3'b000, "p_regrant_after_gap"));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, "p_one_cycle_grant_tail"));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, "p_gap_to_idle"));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, "tail_in_idle_ignored"));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, "still_idle"));
        // C1 both requesting, tail every third BUSY cycle
        vecs.push_back(mk(0, 2'b00, 2'b11, 2'b00, 3'b000, 2'b00, 2'b01, 2'b00, 3'b010, 3'b000, "c1_rr_a1"));
        vecs.push_back(mk(0, 2'b00, 2'b11, 2'b00, 3'b000, 2'b00, 2'b01, 2'b00, 3'b010, 3'b000, "c1_rr_a2"));
        vecs.push_back(mk(0, 2'b00, 2'b11, 2'b00, 3'b010, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, "c1_rr_gap1"));
        vecs.push_back(mk(0, 2'b00, 2'b11, 2'b00, 3'b000, 2'b00, 2'b10, 2'b00, 3'b010, 3'b000, "c1_rr_b1"));
        vecs.push_back(mk(0, 2'b00, 2'b11, 2'b00, 3'b000, 2'b00, 2'b10, 2'b00, 3'b010, 3'b000, "c1_rr_b2"));
        vecs.push_back(mk(0, 2'b00, 2'b11, 2'b00, 3'b010, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, "c1_rr_gap2"));
        vecs.push_back(mk(0, 2'b00, 2'b11, 2'b00, 3'b000, 2'b00, 2'b01, 2'b00, 3'b010, 3'b000, "c1_rr_c1"));
        vecs.push_back(mk(0, 2'b00, 2'b11, 2'b00, 3'b000, 2'b00, 2'b01, 2'b00, 3'b010, 3'b000, "c1_rr_c2"));
        vecs.push_back(mk(0, 2'b00, 2'b11, 2'b00, 3'b010, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, "c1_rr_gap3"));
        vecs.push_back(mk(0, 2'b00, 2'b11, 2'b00, 3'b000, 2'b00, 2'b10, 2'b00, 3'b010, 3'b000, "c1_rr_d1"));
        vecs.push_back(mk(0, 2'b00, 2'b11, 2'b00, 3'b010, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, "c1_rr_gap4"));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, "c1_idle"));
        // C2 request dropped before tail keeps grant
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b10, 3'b000, 2'b00, 2'b00, 2'b10, 3'b100, 3'b000, "c2_grant"));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 2'b10, 3'b100, 3'b000, "c2_req_drop_hold1"));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 2'b10, 3'b100, 3'b000, "c2_req_drop_hold2"));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b100, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, "c2_tail_release"));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, "c2_idle"));
        // All three outputs together, independent pointers and tails
        vecs.push_back(mk(0, 2'b11, 2'b11, 2'b11, 3'b000, 2'b10, 2'b01, 2'b01, 3'b111, 3'b000, "all_three_grant"));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10, 2'b01, 2'b01, 3'b111, 3'b000, "all_three_hold"));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b001, 2'b00, 2'b01, 2'b01, 3'b110, 3'b000, "p_tail_only"));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b110, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, "c1_c2_tails"));
        // Reset mid-packet
        vecs.push_back(mk(0, 2'b10, 2'b00, 2'b00, 3'b000, 2'b10, 2'b00, 2'b00, 3'b001, 3'b000, "p_grant_in1"));
        vecs.push_back(mk(0, 2'b10, 2'b00, 2'b00, 3'b000, 2'b10, 2'b00, 2'b00, 3'b001, 3'b000, "p_grant_in1_hold"));
        vecs.push_back(mk(1, 2'b10, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, "reset_mid_packet"));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 3'b000, 2'b01, 2'b00, 2'b00, 3'b001, 3'b000, "ptr_after_reset_a"));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, "p_tail_after_reset"));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, "p_idle_ptr1"));
        vecs.push_back(mk(0, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00, 2'b10, 2'b00, 3'b010, 3'b000, "c1_grant_in1"));
        vecs.push_back(mk(1, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, "reset_clears_c1"));
        vecs.push_back(mk(0, 2'b11, 2'b11, 2'b00, 3'b000, 2'b01, 2'b01, 2'b00, 3'b011, 3'b000, "ptr_reset_to_in0"));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b011, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, "tails_release"));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, "final_idle"));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // Long packet without tail: watchdog release or indefinite hold
        applyStimulus(mk(0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b01, 2'b00, 2'b00, 3'b001, 3'b000, "hold_grant"));
        for (int i = 2; i <= 120; i++) begin
`ifdef ROUTER10_GRANT_WATCHDOG_EN
            eg = (i <= TMO) ? 2'b01 : 2'b00;
            eb = (i <= TMO) ? 3'b001 : 3'b000;
            et = (i <= TMO) ? 3'b000 : 3'b001;
`else
            eg = 2'b01;
            eb = 3'b001;
            et = 3'b000;
`endif
            v = mk(0, 2'b00, 2'b00, 2'b00, 3'b000, eg, 2'b00, 2'b00, eb, et, $sformatf("hold_cycle_%0d", i));
            applyStimulus(v);
        end
`ifdef ROUTER10_GRANT_WATCHDOG_EN
        et = 3'b001;
`else
        et = 3'b000;
`endif
        applyStimulus(mk(0, 2'b00, 2'b00, 2'b00, 3'b001, 2'b00, 2'b00, 2'b00, 3'b000, et, "hold_tail_end"));
        applyStimulus(mk(1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, "reset_clears_terr"));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
